log_lane_scheduler: RTL and testbench



---
 rtl/log_lane_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_log_lane_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_lane_scheduler.sv
// Log lane scheduler: owns the per-lane speed dividers, rescales them on a
// level change (one lane per cycle) and issues one-cycle move ticks per lane.
//
// Handshake: level_load is a single-cycle pulse. It is accepted in every
// state and takes priority over everything else. busy is high for the
// six cycles that follow while the dividers are rewritten. There is no
// ready/valid back-pressure: the caller watches busy and running.
module log_lane_scheduler #(
    parameter int         NUM_LANES   = 6,
    parameter int         DIV_W       = 24,
    parameter int         BASE_DIV0   = 200000,
    parameter int         BASE_DIV1   = 90000,
    parameter int         BASE_DIV2   = 275000,
    parameter int         BASE_DIV3   = 190000,
    parameter int         BASE_DIV4   = 350000,
    parameter int         BASE_DIV5   = 150000,
    parameter logic [5:0] DIR_MASK    = 6'b100110,
    parameter int         SCALE_SHIFT = 4,
    parameter int         MAX_LEVEL   = 8,
    parameter int         MIN_DIV     = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           level,
    input  logic                 level_load,
    input  logic                 run_en,
    input  logic                 pause,
    output logic [NUM_LANES-1:0] tick,
    output logic [NUM_LANES-1:0] dir,
    output logic                 busy,
    output logic                 running,
    output logic [3:0]           cur_level,
    input  logic [2:0]           div_rd_sel,
    output logic [DIV_W-1:0]     div_rd_data
);

    // Divider arithmetic is carried out with 4 guard bits.
    localparam int EXT_W = DIV_W + 4;

    localparam logic [DIV_W-1:0] BASE_DIV [NUM_LANES] = '{
        DIV_W'(BASE_DIV0), DIV_W'(BASE_DIV1), DIV_W'(BASE_DIV2),
        DIV_W'(BASE_DIV3), DIV_W'(BASE_DIV4), DIV_W'(BASE_DIV5)
    };

    localparam logic [2:0] LAST_IDX = 3'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t               state;
    logic [2:0]           load_idx;
    logic [DIV_W-1:0]     eff_div [NUM_LANES];
    logic [DIV_W-1:0]     cnt     [NUM_LANES];
    logic [NUM_LANES-1:0] term;
    logic [EXT_W-1:0]     base_ext;
    logic [EXT_W-1:0]     step_ext;
    logic [EXT_W-1:0]     d_ext;
    logic [EXT_W-1:0]     new_div;

    // Requested levels above MAX_LEVEL scale as MAX_LEVEL.
    function automatic logic [3:0] clamp_level(input logic [3:0] l);
        if (int'(l) > MAX_LEVEL) begin
            return 4'(MAX_LEVEL);
        end
        return l;
    endfunction

    assign dir = DIR_MASK;

    // Scaled divider for the lane currently being rewritten, floored at MIN_DIV.
    always_comb begin
        base_ext = EXT_W'(BASE_DIV[load_idx]);
        step_ext = base_ext >> SCALE_SHIFT;
        d_ext    = base_ext - step_ext * EXT_W'(cur_level);
        new_div  = (d_ext < EXT_W'(MIN_DIV)) ? EXT_W'(MIN_DIV) : d_ext;
    end

    // Terminal count per lane: the counter wraps after eff_div cycles.
    always_comb begin
        term = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            term[i] = (cnt[i] == eff_div[i] - DIV_W'(1));
        end
    end

    // Divider readback; lane numbers past the last lane read as zero.
    always_comb begin
        div_rd_data = '0;
        if (int'(div_rd_sel) < NUM_LANES) begin
            div_rd_data = eff_div[div_rd_sel];
        end
    end

    // Sequencer: state, dividers, lane counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick      <= '0;
            busy      <= 1'b0;
            running   <= 1'b0;
            cur_level <= 4'd0;
            load_idx  <= 3'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                eff_div[i] <= BASE_DIV[i];
                cnt[i]     <= '0;
            end
        end else begin
            // Ticks and status only survive a cycle when restated below.
            tick    <= '0;
            busy    <= 1'b0;
            running <= 1'b0;
            if (level_load) begin
                // A new level always restarts the rewrite from lane 0.
                state     <= LOAD;
                busy      <= 1'b1;
                cur_level <= clamp_level(level);
                load_idx  <= 3'd0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run_en) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    LOAD: begin
                        eff_div[load_idx] <= new_div[DIV_W-1:0];
                        if (load_idx == LAST_IDX) begin
                            load_idx <= 3'd0;
                            if (run_en) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            load_idx <= load_idx + 3'd1;
                            busy     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!run_en) begin
                            state <= IDLE;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                cnt[i] <= '0;
                            end
                        end else if (pause) begin
                            // Counters hold so the resumed period is not cut short.
                            state <= PAUSE;
                        end else begin
                            running <= 1'b1;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (term[i]) begin
                                    cnt[i]  <= '0;
                                    tick[i] <= 1'b1;
                                end else begin
                                    cnt[i] <= cnt[i] + DIV_W'(1);
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (!run_en) begin
                            state <= IDLE;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                cnt[i] <= '0;
                            end
                        end else if (!pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_log_lane_scheduler.sv
// Bench for log_lane_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural lane model.
module tb_log_lane_scheduler;

    localparam int NL    = 6;
    localparam int DW    = 24;
    localparam int SH    = 4;
    localparam int MAXL  = 8;
    localparam int MIN_A = 4;
    localparam int BASE_A [NL] = '{32, 20, 64, 64, 64, 64};

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;

    // Clock and inputs
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n    = 1'b0;
    logic [3:0]    level      = 4'd0;
    logic          level_load = 1'b0;
    logic          run_en     = 1'b0;
    logic          pause      = 1'b0;
    logic [2:0]    div_rd_sel = 3'd0;

    logic [NL-1:0] tick_a, dir_a, tick_b, dir_b, tick_c, dir_c;
    logic          busy_a, running_a, busy_b, running_b, busy_c, running_c;
    logic [3:0]    cur_level_a, cur_level_b, cur_level_c;
    logic [DW-1:0] div_a, div_b, div_c;

    // Main instance used for all per-cycle checking.
    log_lane_scheduler #(
        .NUM_LANES(NL), .DIV_W(DW),
        .BASE_DIV0(32), .BASE_DIV1(20), .BASE_DIV2(64),
        .BASE_DIV3(64), .BASE_DIV4(64), .BASE_DIV5(64),
        .DIR_MASK(6'b100110), .SCALE_SHIFT(SH), .MAX_LEVEL(MAXL), .MIN_DIV(MIN_A)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .level(level), .level_load(level_load),
        .run_en(run_en), .pause(pause), .tick(tick_a), .dir(dir_a),
        .busy(busy_a), .running(running_a), .cur_level(cur_level_a),
        .div_rd_sel(div_rd_sel), .div_rd_data(div_a)
    );

    // Small base divider: the per-level step shifts down to zero.
    log_lane_scheduler #(
        .NUM_LANES(NL), .DIV_W(DW),
        .BASE_DIV0(6), .BASE_DIV1(20), .BASE_DIV2(64),
        .BASE_DIV3(64), .BASE_DIV4(64), .BASE_DIV5(64),
        .DIR_MASK(6'b100110), .SCALE_SHIFT(SH), .MAX_LEVEL(MAXL), .MIN_DIV(MIN_A)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .level(level), .level_load(level_load),
        .run_en(run_en), .pause(pause), .tick(tick_b), .dir(dir_b),
        .busy(busy_b), .running(running_b), .cur_level(cur_level_b),
        .div_rd_sel(div_rd_sel), .div_rd_data(div_b)
    );

    // High floor: the scaled divider drops below MIN_DIV.
    log_lane_scheduler #(
        .NUM_LANES(NL), .DIV_W(DW),
        .BASE_DIV0(40), .BASE_DIV1(20), .BASE_DIV2(64),
        .BASE_DIV3(64), .BASE_DIV4(64), .BASE_DIV5(64),
        .DIR_MASK(6'b100110), .SCALE_SHIFT(SH), .MAX_LEVEL(MAXL), .MIN_DIV(30)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .level(level), .level_load(level_load),
        .run_en(run_en), .pause(pause), .tick(tick_c), .dir(dir_c),
        .busy(busy_c), .running(running_c), .cur_level(cur_level_c),
        .div_rd_sel(div_rd_sel), .div_rd_data(div_c)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: lane progress is counted as elapsed counting
    // cycles since the last clear; a lane ticks whenever that count is a
    // whole multiple of its divider.
    int            m_mode;
    int            m_lvl;
    int            m_idx;
    int            m_div     [NL];
    int            m_elapsed [NL];
    logic [NL-1:0] m_tick;

    function automatic int exp_div(input int base, input int lvl);
        int d;
        d = base - lvl * (base >> SH);
        if (d < MIN_A) d = MIN_A;
        return d;
    endfunction

    function automatic int clamp_lvl(input int l);
        return (l > MAXL) ? MAXL : l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_elapsed[i] = 0;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_lvl  = 0;
        m_idx  = 0;
        m_tick = '0;
        for (int i = 0; i < NL; i++) m_div[i] = BASE_A[i];
        model_clear();
    endtask

    task automatic model_step();
        logic [NL-1:0] t;
        t = '0;
        if (level_load) begin
            m_mode = M_LOAD;
            m_lvl  = clamp_lvl(int'(level));
            m_idx  = 0;
            model_clear();
        end else begin
            case (m_mode)
                M_IDLE: if (run_en) m_mode = M_RUN;
                M_LOAD: begin
                    m_div[m_idx] = exp_div(BASE_A[m_idx], m_lvl);
                    if (m_idx == NL - 1) begin
                        m_idx  = 0;
                        m_mode = run_en ? M_RUN : M_IDLE;
                    end else begin
                        m_idx++;
                    end
                end
                M_RUN: begin
                    if (!run_en) begin
                        m_mode = M_IDLE;
                        model_clear();
                    end else if (pause) begin
                        m_mode = M_PAUSE;
                    end else begin
                        for (int i = 0; i < NL; i++) begin
                            m_elapsed[i]++;
                            if (m_elapsed[i] % m_div[i] == 0) t[i] = 1'b1;
                        end
                    end
                end
                default: begin
                    if (!run_en) begin
                        m_mode = M_IDLE;
                        model_clear();
                    end else if (!pause) begin
                        m_mode = M_RUN;
                    end
                end
            endcase
        end
        m_tick = t;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Per-cycle compare against the model, on the falling edge.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("tick", tick_a, m_tick);
            check("busy", busy_a, (m_mode == M_LOAD) ? 1 : 0);
            check("running", running_a, (m_mode == M_RUN) ? 1 : 0);
            check("cur_level", cur_level_a, m_lvl);
            check("dir", dir_a, 6'b100110);
            check("div_rd_data", div_a, (int'(div_rd_sel) < NL) ? m_div[div_rd_sel] : 0);
        end
    end

    // Driver helpers
    task automatic rd(input logic [2:0] s, output int va, output int vb, output int vc);
        @(negedge clk);
        #1;
        div_rd_sel = s;
        #1;
        va = int'(div_a);
        vb = int'(div_b);
        vc = int'(div_c);
    endtask

    task automatic count_to_tick(input int lane, input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (tick_a[lane]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_load(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
        end
    endtask

    task automatic pulse_load(input logic [3:0] l);
        level      = l;
        level_load = 1'b1;
        @(posedge clk);
        #1;
        level_load = 1'b0;
    endtask

    // Directed scenarios, then randomized traffic, then the report.
    initial begin
        int n, va, vb, vc, quiet;

        repeat (3) @(posedge clk);
        #1;
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // Reset values
        check("rst_tick", tick_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_running", running_a, 0);
        check("rst_cur_level", cur_level_a, 0);
        rd(3'd0, va, vb, vc); check("rst_div0", va, 32);
        rd(3'd1, va, vb, vc); check("rst_div1", va, 20);
        rd(3'd6, va, vb, vc); check("rst_div_sel6", va, 0);
        check("rst_dir", dir_a, 6'b100110);

        // Level 0 run: first tick and periods
        @(posedge clk);
        #1;
        run_en = 1'b1;
        @(posedge clk);
        count_to_tick(0, 100, n); check("l0_first_tick0", n, 32);
        count_to_tick(0, 100, n); check("l0_period0", n, 32);
        count_to_tick(1, 100, n);
        count_to_tick(1, 100, n); check("l0_period1", n, 20);

        // Level 2 load
        pulse_load(4'd2);
        wait_load(n); check("l2_busy_len", n, 6);
        rd(3'd0, va, vb, vc); check("l2_div0", va, 28);
        count_to_tick(0, 100, n);
        count_to_tick(0, 100, n); check("l2_period0", n, 28);

        // Level 15 clamps to 8; overridden instances check shift-to-zero and floor
        pulse_load(4'd15);
        wait_load(n); check("l15_busy_len", n, 6);
        check("l15_cur_level", cur_level_a, 8);
        rd(3'd0, va, vb, vc);
        check("l15_div0", va, 16);
        check("l8_zero_step_div0", vb, 6);
        check("l8_floor_div0", vc, 30);
        rd(3'd1, va, vb, vc); check("l15_div1", va, 12);
        rd(3'd2, va, vb, vc); check("l15_div2", va, 32);

        // Pause at counter 10 for about 50 cycles
        pulse_load(4'd0);
        wait_load(n);
        repeat (10) @(posedge clk);
        #1;
        pause = 1'b1;
        quiet = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tick_a != '0) quiet++;
        end
        check("pause_no_ticks", quiet, 0);
        pause = 1'b0;
        @(posedge clk);
        count_to_tick(0, 100, n); check("pause_resume_tick0", n, 22);

        // Load restarted at index 3, then reset mid-run
        pulse_load(4'd5);
        repeat (3) @(posedge clk);
        #1;
        pulse_load(4'd3);
        wait_load(n); check("restart_busy_len", n, 6);
        check("restart_cur_level", cur_level_a, 3);
        rd(3'd0, va, vb, vc); check("restart_div0", va, 26);
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrun_rst_tick", tick_a, 0);
        check("midrun_rst_busy", busy_a, 0);
        check("midrun_rst_running", running_a, 0);
        check("midrun_rst_cur_level", cur_level_a, 0);
        rd(3'd0, va, vb, vc); check("midrun_rst_div0", va, 32);
        rd(3'd5, va, vb, vc); check("midrun_rst_div5", va, 64);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #1;
            reset_n    = ($urandom_range(0, 1499) != 0);
            level_load = ($urandom_range(0, 199) == 0);
            level      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) run_en = ~run_en;
            if ($urandom_range(0, 49) == 0) pause  = ~pause;
            div_rd_sel = 3'($urandom_range(0, 7));
        end
        @(posedge clk);
        #1;
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
